fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction fetch stage of the RV32I core. It sits directly upstream of decode and execute, and feeds them one instruction per cycle.
- Holds the PC and a word-organised instruction memory built from 4 byte lanes. It applies the same lane byte-order rule as the data-memory path.
- Presents a registered instruction and PC pair over a valid/ready handshake.
- Accepts redirects from the next-PC logic and traps misaligned redirect targets.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.
- IMEM_WORDS, 256, instruction memory depth in 32-bit words (power of 2).
- AW, 8, word-index width; must equal log2(IMEM_WORDS).

Ports:
- clk  in  1  clock, rising edge.
- rstd  in  1  reset: synchronous, active-low, sampled on the rising edge of clk.
- out_ready  in  1  decode can accept the instruction this cycle.
- redirect  in  1  next-PC logic requests a PC change (branch, jump, trap).
- redirect_pc  in  32  target PC, valid when redirect=1.
- imem_wren  in  1  instruction-memory write enable, active-low (program load).
- imem_wa  in  AW  write word index.
- imem_wd  in  32  write word, in memory byte-lane order.
- out_valid  out  1  inst and inst_pc are valid.
- inst  out  32  instruction in little-endian assembled form.
- inst_pc  out  32  address of inst.
- fault  out  1  misaligned-fetch fault is latched.
- fault_pc  out  32  offending redirect target.
- fetch_count  out  32  number of instructions accepted by decode.

Behaviour:
- Reset (rstd=0 at a rising edge):
  - pc<=RESET_PC, state<=RUN.
  - out_valid, inst, inst_pc, fault, fault_pc and fetch_count all <=0.
  - Memory contents are not cleared.
- Memory:
  - Word index is pc[AW+1:2]. Upper PC bits are ignored, so addresses wrap modulo IMEM_WORDS*4.
  - Read is combinational.
  - Write happens on the rising edge when imem_wren=0.
  - Lane order: the lowest-address byte is stored in bits [7:0] of the raw word.
  - inst = {raw[7:0], raw[15:8], raw[23:16], raw[31:24]}.
- Advance condition: adv = !out_valid || out_ready.
- State machine, two states: RUN and FAULT.
- RUN, evaluated at each rising edge in priority order:
  1. redirect=1 with redirect_pc[1:0]!=0:
     - out_valid<=0, fault<=1, fault_pc<=redirect_pc, state<=FAULT.
  2. redirect=1 with an aligned target:
     - Flush: out_valid<=0, pc<=redirect_pc.
     - This applies even while stalled; a held instruction is discarded.
     - The flushed instruction is not counted, even if out_ready=1 in the same cycle.
  3. adv=1:
     - inst<=swap(mem[pc]), inst_pc<=pc, out_valid<=1, pc<=pc+4. The addition wraps mod 2^32.
  4. Otherwise hold:
     - inst, inst_pc, out_valid and pc are all unchanged.
- Latency:
  - One cycle from PC to a valid output.
  - The first instruction appears after the first rising edge with rstd=1.
  - The first instruction after an aligned redirect appears one cycle later, giving one bubble cycle.
- Throughput: one instruction per cycle while out_ready=1.
- fetch_count:
  - Increments by 1 on every edge where out_valid && out_ready && !redirect (and state is RUN).
  - Wraps at 2^32.
- FAULT:
  - out_valid=0; pc, fault and fault_pc are held.
  - redirect is ignored. Only reset exits this state.
  - Memory writes still take effect.
- Simultaneous fetch and write to the same word: the captured inst reflects the old contents. The new word is seen only on the next fetch of that index.
- Reset during operation: reset wins over redirect, over a write in progress and over stall. All outputs take their reset values at that edge.
- Handshake stability: while out_valid=1 and out_ready=0, inst and inst_pc must not change unless redirect=1.

Test Plan:
- Stream:
  - Stimulus: load words 0..3 with raw 32'h13000000+i; release reset; out_ready=1.
  - Required: inst=32'h00000013+(i<<24) at inst_pc=0,4,8,C on consecutive cycles; fetch_count=4.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles after the pc=4 instruction appears.
  - Required: inst_pc holds 4 with out_valid=1 and pc frozen; resumes at 8 the cycle after out_ready=1; no count increment while stalled.
- Redirect while stalled:
  - Stimulus: out_valid=1 and out_ready=0 at inst_pc=8; pulse redirect to 32'h40.
  - Required: next cycle out_valid=0; following cycle inst_pc=32'h40; fetch_count unchanged by the flushed pc=8 instruction.
- Misaligned redirect:
  - Stimulus: redirect_pc=32'h42.
  - Required: fault=1 and fault_pc=32'h42 from the next cycle; out_valid stays 0; a later aligned redirect is ignored; reset clears fault.
- Wrap:
  - Stimulus: with IMEM_WORDS=256, redirect to 32'h3FC, then let fetch continue.
  - Required: the next fetch has inst_pc=32'h400 and returns the contents of word 0.
- Reset mid-stream plus write race:
  - Stimulus: rstd=0 for one edge while out_valid=1.
  - Required: all outputs 0 and the first post-reset inst_pc equals RESET_PC.
  - Stimulus: separately, write word 5 in the same edge as fetching pc=20.
  - Required: inst holds the old word 5 contents.

Source files
------------

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: PC register, byte-lane instruction memory and a
// registered instruction/PC pair offered to decode over a valid/ready handshake.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 256,
    parameter int          AW         = 8
) (
    input  logic          clk,
    input  logic          rstd,
    input  logic          out_ready,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    input  logic          imem_wren,
    input  logic [AW-1:0] imem_wa,
    input  logic [31:0]   imem_wd,
    output logic          out_valid,
    output logic [31:0]   inst,
    output logic [31:0]   inst_pc,
    output logic          fault,
    output logic [31:0]   fault_pc,
    output logic [31:0]   fetch_count
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FAULT = 1'b1;

    logic          state;
    logic [31:0]   pc;
    logic [31:0]   mem [IMEM_WORDS];
    logic [AW-1:0] rd_idx;
    logic [31:0]   raw_word;
    logic [31:0]   swapped_word;
    logic          adv;
    logic          misaligned;

    assign rd_idx       = pc[AW+1:2];
    assign raw_word     = mem[rd_idx];
    assign swapped_word = {raw_word[7:0], raw_word[15:8], raw_word[23:16], raw_word[31:24]};
    assign adv          = !out_valid || out_ready;
    assign misaligned   = redirect_pc[1:0] != 2'b00;

    // Program-load port; independent of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (!imem_wren) begin
            mem[imem_wa] <= imem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstd) begin
            state       <= ST_RUN;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            inst        <= 32'h0;
            inst_pc     <= 32'h0;
            fault       <= 1'b0;
            fault_pc    <= 32'h0;
            fetch_count <= 32'h0;
        end else begin
            case (state)
                ST_RUN: begin
                    // A redirect flushes the presented instruction, so it is never counted.
                    if (out_valid && out_ready && !redirect) begin
                        fetch_count <= fetch_count + 32'd1;
                    end
                    if (redirect && misaligned) begin
                        out_valid <= 1'b0;
                        fault     <= 1'b1;
                        fault_pc  <= redirect_pc;
                        state     <= ST_FAULT;
                    end else if (redirect) begin
                        out_valid <= 1'b0;
                        pc        <= redirect_pc;
                    end else if (adv) begin
                        inst      <= swapped_word;
                        inst_pc   <= pc;
                        out_valid <= 1'b1;
                        pc        <= pc + 32'd4;
                    end
                end
                ST_FAULT: begin
                    out_valid <= 1'b0;
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule
